// File: rtl/wb_pkg.sv
// Shared types, codes and helpers for the writeback stage.
// Optional MMX destination and 8-byte stores: define WB_MMX_EN.
package wb_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WADDR_W = ADDR_W - 2;
    localparam int unsigned RES_W   = 64;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned GPR_W   = 32;
    localparam int unsigned SEG_W   = 16;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned NB_W    = 4;

`ifdef WB_MMX_EN
    localparam bit          MMX_EN    = 1'b1;
    localparam int unsigned MAX_BEATS = 3;
`else
    localparam bit          MMX_EN    = 1'b0;
    localparam int unsigned MAX_BEATS = 2;
`endif
    localparam int unsigned BEAT_W    = (MAX_BEATS > 2) ? 2 : 1;
    localparam int unsigned SPLIT_D_W = WORD_W * MAX_BEATS;
    localparam int unsigned SPLIT_M_W = BE_W * MAX_BEATS;

    localparam logic [2:0] OPSIZE_1B = 3'b001;
    localparam logic [2:0] OPSIZE_2B = 3'b010;
    localparam logic [2:0] OPSIZE_4B = 3'b011;
    localparam logic [2:0] OPSIZE_8B = 3'b100;

    localparam logic [1:0] STACK_NONE = 2'b00;
    localparam logic [1:0] STACK_PUSH = 2'b01;
    localparam logic [1:0] STACK_POP  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BEAT = 1'b1
    } wb_state_e;

    typedef enum logic [2:0] {
        DEST_NONE = 3'd0,
        DEST_GPR  = 3'd1,
        DEST_SEG  = 3'd2,
        DEST_MMX  = 3'd3,
        DEST_MEM  = 3'd4
    } wb_dest_e;

    // Fields of an accepted store kept while its beats drain.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [RES_W-1:0]  result;
        logic [NB_W-1:0]   nbytes;
        logic [ADDR_W-1:0] pc;
    } wb_hold_t;

    function automatic logic [NB_W-1:0] size_bytes(input logic [2:0] opsize);
        case (opsize)
            OPSIZE_1B: return 4'd1;
            OPSIZE_2B: return 4'd2;
            OPSIZE_8B: return MMX_EN ? 4'd8 : 4'd4;
            default:   return 4'd4;
        endcase
    endfunction

    // Reserved codes collapse to the 4-byte code.
    function automatic logic [2:0] size_code(input logic [2:0] opsize);
        case (opsize)
            OPSIZE_1B, OPSIZE_2B, OPSIZE_4B: return opsize;
            OPSIZE_8B: return MMX_EN ? OPSIZE_8B : OPSIZE_4B;
            default:   return OPSIZE_4B;
        endcase
    endfunction

endpackage

// File: rtl/wb_store_splitter.sv
// Combinational lane placement for a memory store: shifted data, byte-enable
// mask and index of the last beat, presented as per-beat slices.
module wb_store_splitter
    import wb_pkg::*;
(
    input  logic [1:0]                       offset,
    input  logic [NB_W-1:0]                  nbytes,
    input  logic [RES_W-1:0]                 result,
    output logic [MAX_BEATS-1:0][WORD_W-1:0] beat_data,
    output logic [MAX_BEATS-1:0][BE_W-1:0]   beat_be,
    output logic [BEAT_W-1:0]                last_beat
);

    logic [SPLIT_D_W-1:0] shifted;
    logic [SPLIT_M_W-1:0] mask;
    logic [NB_W-1:0]      span;

    always_comb begin
        shifted = SPLIT_D_W'(result) << {offset, 3'b000};
        mask    = ((SPLIT_M_W'(1) << nbytes) - SPLIT_M_W'(1)) << offset;
        span    = NB_W'(offset) + nbytes - NB_W'(1);
    end

    assign beat_data = shifted;
    assign beat_be   = mask;
    assign last_beat = BEAT_W'(span >> 2);

endmodule

// File: rtl/writeback_top.sv
// Writeback stage: retires results into GPR/segment/MMX registers or memory,
// with memory stores split into aligned 32-bit beats. MMX support: WB_MMX_EN.
module writeback_top
    import wb_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic [ADDR_W-1:0]   wb_dest_address,
    input  logic [31:0]         wb_dest_reg,
    input  logic [RES_W-1:0]    wb_result,
    input  logic [2:0]          wb_opsize,
    input  logic [1:0]          wb_stack_op,
    input  logic                wb_op_a_is_address,
    input  logic                wb_op_a_is_reg,
    input  logic                wb_op_a_is_segment,
    input  logic                wb_op_a_is_mmx,
    input  logic [ADDR_W-1:0]   wb_pc,
    output logic                gpr_we,
    output logic [SEL_W-1:0]    gpr_sel,
    output logic [2:0]          gpr_size,
    output logic [GPR_W-1:0]    gpr_data,
    output logic                seg_we,
    output logic [SEL_W-1:0]    seg_sel,
    output logic [SEG_W-1:0]    seg_data,
    output logic                mmx_we,
    output logic [SEL_W-1:0]    mmx_sel,
    output logic [RES_W-1:0]    mmx_data,
    output logic                esp_inc,
    output logic                esp_dec,
    output logic [NB_W-1:0]     esp_delta,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [WORD_W-1:0]   mem_req_data,
    output logic [BE_W-1:0]     mem_req_be,
    output logic                retire_valid,
    output logic [ADDR_W-1:0]   retire_pc
);

    wb_state_e              state, state_d;
    logic [BEAT_W-1:0]      beat, beat_d, next_beat;
    wb_hold_t               hold, hold_d;
    wb_dest_e               dest;
    logic                   accept;
    logic [NB_W-1:0]        in_bytes;

    logic                   ready_d, gpr_we_d, seg_we_d, mmx_we_d;
    logic                   esp_inc_d, esp_dec_d, mem_valid_d, retire_valid_d;
    logic [SEL_W-1:0]       gpr_sel_d, seg_sel_d, mmx_sel_d;
    logic [2:0]             gpr_size_d;
    logic [GPR_W-1:0]       gpr_data_d;
    logic [SEG_W-1:0]       seg_data_d;
    logic [RES_W-1:0]       mmx_data_d;
    logic [NB_W-1:0]        esp_delta_d;
    logic [ADDR_W-1:0]      mem_addr_d, retire_pc_d;
    logic [WORD_W-1:0]      mem_data_d;
    logic [BE_W-1:0]        mem_be_d;

    logic [1:0]                       split_off;
    logic [NB_W-1:0]                  split_bytes;
    logic [RES_W-1:0]                 split_res;
    logic [MAX_BEATS-1:0][WORD_W-1:0] split_data;
    logic [MAX_BEATS-1:0][BE_W-1:0]   split_be;
    logic [BEAT_W-1:0]                split_last;

`ifdef WB_MMX_EN
    logic unused_bits;
    assign unused_bits = ^wb_dest_reg[31:SEL_W];
`else
    logic unused_bits;
    assign unused_bits = ^{wb_dest_reg[31:SEL_W], wb_op_a_is_mmx};
`endif

    assign accept    = wb_valid & wb_ready;
    assign in_bytes  = size_bytes(wb_opsize);
    assign next_beat = beat + BEAT_W'(1);

    // Destination class: push overrides the flags, then mmx > seg > reg > mem.
    always_comb begin
        dest = DEST_NONE;
        if (wb_stack_op == STACK_PUSH)  dest = DEST_MEM;
`ifdef WB_MMX_EN
        else if (wb_op_a_is_mmx)        dest = DEST_MMX;
`endif
        else if (wb_op_a_is_segment)    dest = DEST_SEG;
        else if (wb_op_a_is_reg)        dest = DEST_GPR;
        else if (wb_op_a_is_address)    dest = DEST_MEM;
    end

    // The splitter sees the incoming store at accept and the held one afterwards.
    always_comb begin
        if (state == ST_IDLE) begin
            split_off   = wb_dest_address[1:0];
            split_bytes = in_bytes;
            split_res   = wb_result;
        end else begin
            split_off   = hold.addr[1:0];
            split_bytes = hold.nbytes;
            split_res   = hold.result;
        end
    end

    wb_store_splitter u_splitter (
        .offset    (split_off),
        .nbytes    (split_bytes),
        .result    (split_res),
        .beat_data (split_data),
        .beat_be   (split_be),
        .last_beat (split_last)
    );

    always_comb begin
        state_d        = state;
        beat_d         = beat;
        hold_d         = hold;
        ready_d        = 1'b0;
        gpr_we_d       = 1'b0;
        seg_we_d       = 1'b0;
        mmx_we_d       = 1'b0;
        esp_inc_d      = 1'b0;
        esp_dec_d      = 1'b0;
        retire_valid_d = 1'b0;
        mem_valid_d    = mem_req_valid;
        gpr_sel_d      = gpr_sel;
        gpr_size_d     = gpr_size;
        gpr_data_d     = gpr_data;
        seg_sel_d      = seg_sel;
        seg_data_d     = seg_data;
        mmx_sel_d      = mmx_sel;
        mmx_data_d     = mmx_data;
        esp_delta_d    = esp_delta;
        mem_addr_d     = mem_req_addr;
        mem_data_d     = mem_req_data;
        mem_be_d       = mem_req_be;
        retire_pc_d    = retire_pc;

        case (state)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    hold_d.addr   = wb_dest_address;
                    hold_d.result = wb_result;
                    hold_d.nbytes = in_bytes;
                    hold_d.pc     = wb_pc;
                    if (wb_stack_op == STACK_PUSH) begin
                        esp_dec_d   = 1'b1;
                        esp_delta_d = in_bytes;
                    end else if (wb_stack_op == STACK_POP) begin
                        esp_inc_d   = 1'b1;
                        esp_delta_d = in_bytes;
                    end
                    if (dest == DEST_MEM) begin
                        state_d     = ST_BEAT;
                        ready_d     = 1'b0;
                        beat_d      = '0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {wb_dest_address[ADDR_W-1:2], 2'b00};
                        mem_data_d  = split_data[0];
                        mem_be_d    = split_be[0];
                    end else begin
                        retire_valid_d = 1'b1;
                        retire_pc_d    = wb_pc;
                        case (dest)
                            DEST_GPR: begin
                                gpr_we_d   = 1'b1;
                                gpr_sel_d  = wb_dest_reg[SEL_W-1:0];
                                gpr_size_d = size_code(wb_opsize);
                                gpr_data_d = wb_result[GPR_W-1:0];
                            end
                            DEST_SEG: begin
                                seg_we_d   = 1'b1;
                                seg_sel_d  = wb_dest_reg[SEL_W-1:0];
                                seg_data_d = wb_result[SEG_W-1:0];
                            end
`ifdef WB_MMX_EN
                            DEST_MMX: begin
                                mmx_we_d   = 1'b1;
                                mmx_sel_d  = wb_dest_reg[SEL_W-1:0];
                                mmx_data_d = wb_result;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            ST_BEAT: begin
                if (mem_req_ready) begin
                    if (beat == split_last) begin
                        state_d        = ST_IDLE;
                        ready_d        = 1'b1;
                        mem_valid_d    = 1'b0;
                        retire_valid_d = 1'b1;
                        retire_pc_d    = hold.pc;
                    end else begin
                        beat_d     = next_beat;
                        mem_addr_d = {hold.addr[ADDR_W-1:2] + WADDR_W'(next_beat), 2'b00};
                        mem_data_d = split_data[next_beat];
                        mem_be_d   = split_be[next_beat];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            beat          <= '0;
            hold          <= '0;
            wb_ready      <= 1'b0;
            gpr_we        <= 1'b0;
            gpr_sel       <= '0;
            gpr_size      <= '0;
            gpr_data      <= '0;
            seg_we        <= 1'b0;
            seg_sel       <= '0;
            seg_data      <= '0;
            mmx_we        <= 1'b0;
            mmx_sel       <= '0;
            mmx_data      <= '0;
            esp_inc       <= 1'b0;
            esp_dec       <= 1'b0;
            esp_delta     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_be    <= '0;
            retire_valid  <= 1'b0;
            retire_pc     <= '0;
        end else begin
            state         <= state_d;
            beat          <= beat_d;
            hold          <= hold_d;
            wb_ready      <= ready_d;
            gpr_we        <= gpr_we_d;
            gpr_sel       <= gpr_sel_d;
            gpr_size      <= gpr_size_d;
            gpr_data      <= gpr_data_d;
            seg_we        <= seg_we_d;
            seg_sel       <= seg_sel_d;
            seg_data      <= seg_data_d;
            mmx_we        <= mmx_we_d;
            mmx_sel       <= mmx_sel_d;
            mmx_data      <= mmx_data_d;
            esp_inc       <= esp_inc_d;
            esp_dec       <= esp_dec_d;
            esp_delta     <= esp_delta_d;
            mem_req_valid <= mem_valid_d;
            mem_req_addr  <= mem_addr_d;
            mem_req_data  <= mem_data_d;
            mem_req_be    <= mem_be_d;
            retire_valid  <= retire_valid_d;
            retire_pc     <= retire_pc_d;
        end
    end

endmodule

// File: tb/tb_writeback_top.sv
// Self-checking bench for writeback_top: directed scenarios plus randomized
// instructions checked against a byte-level reference model.
module tb_writeback_top;

`ifdef WB_MMX_EN
    localparam bit MMX = 1'b1;
`else
    localparam bit MMX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_dest_address, wb_dest_reg, wb_pc;
    logic [63:0] wb_result;
    logic [2:0]  wb_opsize;
    logic [1:0]  wb_stack_op;
    logic        wb_op_a_is_address, wb_op_a_is_reg, wb_op_a_is_segment, wb_op_a_is_mmx;
    logic        gpr_we, seg_we, mmx_we, esp_inc, esp_dec;
    logic [2:0]  gpr_sel, gpr_size, seg_sel, mmx_sel;
    logic [31:0] gpr_data;
    logic [15:0] seg_data;
    logic [63:0] mmx_data;
    logic [3:0]  esp_delta, mem_req_be;
    logic        mem_req_valid, mem_req_ready, retire_valid;
    logic [31:0] mem_req_addr, mem_req_data, retire_pc;

    int checks = 0;
    int errors = 0;

    writeback_top dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_dest_address(wb_dest_address), .wb_dest_reg(wb_dest_reg),
        .wb_result(wb_result), .wb_opsize(wb_opsize), .wb_stack_op(wb_stack_op),
        .wb_op_a_is_address(wb_op_a_is_address), .wb_op_a_is_reg(wb_op_a_is_reg),
        .wb_op_a_is_segment(wb_op_a_is_segment), .wb_op_a_is_mmx(wb_op_a_is_mmx),
        .wb_pc(wb_pc),
        .gpr_we(gpr_we), .gpr_sel(gpr_sel), .gpr_size(gpr_size), .gpr_data(gpr_data),
        .seg_we(seg_we), .seg_sel(seg_sel), .seg_data(seg_data),
        .mmx_we(mmx_we), .mmx_sel(mmx_sel), .mmx_data(mmx_data),
        .esp_inc(esp_inc), .esp_dec(esp_dec), .esp_delta(esp_delta),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_be(mem_req_be),
        .retire_valid(retire_valid), .retire_pc(retire_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int model_bytes(input logic [2:0] sz);
        if (sz == 3'b001) return 1;
        if (sz == 3'b010) return 2;
        if (sz == 3'b100 && MMX) return 8;
        return 4;
    endfunction

    function automatic logic [2:0] model_code(input logic [2:0] sz);
        if (sz == 3'b001 || sz == 3'b010 || sz == 3'b011) return sz;
        if (sz == 3'b100 && MMX) return sz;
        return 3'b011;
    endfunction

    // 0 none, 1 gpr, 2 seg, 3 mmx, 4 memory
    function automatic int model_dest(input logic [1:0] st, input logic a, input logic r,
                                      input logic s, input logic m);
        if (st == 2'b01) return 4;
        if (m && MMX) return 3;
        if (s) return 2;
        if (r) return 1;
        if (a) return 4;
        return 0;
    endfunction

    // Lane j of beat k carries result byte (4k+j-o) when that byte exists.
    function automatic logic [31:0] model_data(input logic [63:0] res, input int o, input int k);
        logic [31:0] w;
        int idx;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            idx = 4 * k + j - o;
            if (idx >= 0 && idx < 8) w[8*j +: 8] = res[8*idx +: 8];
        end
        return w;
    endfunction

    function automatic logic [3:0] model_be(input int o, input int n, input int k);
        logic [3:0] b;
        int idx;
        b = '0;
        for (int j = 0; j < 4; j++) begin
            idx = 4 * k + j - o;
            if (idx >= 0 && idx < n) b[j] = 1'b1;
        end
        return b;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        wb_valid = 1'b0; wb_dest_address = '0; wb_dest_reg = '0; wb_result = '0;
        wb_opsize = 3'b011; wb_stack_op = 2'b00; wb_pc = '0;
        wb_op_a_is_address = 1'b0; wb_op_a_is_reg = 1'b0;
        wb_op_a_is_segment = 1'b0; wb_op_a_is_mmx = 1'b0;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [2:0] sel, input logic [63:0] res,
                         input logic [2:0] sz, input logic [1:0] st, input logic a,
                         input logic r, input logic s, input logic m, input logic [31:0] pc);
        wb_valid = 1'b1;
        wb_dest_address = addr;
        wb_dest_reg = $urandom();
        wb_dest_reg[2:0] = sel;
        wb_result = res; wb_opsize = sz; wb_stack_op = st; wb_pc = pc;
        wb_op_a_is_address = a; wb_op_a_is_reg = r;
        wb_op_a_is_segment = s; wb_op_a_is_mmx = m;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        mem_req_ready = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wb_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b want=0", wb_ready);
        end
        checks++;
        if ({gpr_we, seg_we, mmx_we, esp_inc, esp_dec, mem_req_valid, retire_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b want=0000000",
                     {gpr_we, seg_we, mmx_we, esp_inc, esp_dec, mem_req_valid, retire_valid});
        end
        checks++;
        if ({gpr_sel, gpr_size, gpr_data, seg_sel, seg_data, mmx_sel, mmx_data, esp_delta,
             mem_req_addr, mem_req_data, mem_req_be, retire_pc} !== '0) begin
            errors++;
            $display("FAIL reset_data gpr=%h seg=%h mmx=%h addr=%h data=%h pc=%h want all 0",
                     gpr_data, seg_data, mmx_data, mem_req_addr, mem_req_data, retire_pc);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got=%b want=1", wb_ready);
        end
    endtask

    task automatic test_reg_write();
        logic [31:0] d, pc;
        logic [2:0]  s;
        drive(32'h0, 3'd3, 64'h0000_0000_1234_5678, 3'b011, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (gpr_we !== 1'b1 || gpr_sel !== 3'd3 || gpr_data !== 32'h1234_5678 || gpr_size !== 3'b011) begin
            errors++;
            $display("FAIL reg_write we=%b sel=%0d data=%h size=%b want 1/3/12345678/011",
                     gpr_we, gpr_sel, gpr_data, gpr_size);
        end
        checks++;
        if (retire_valid !== 1'b1 || retire_pc !== 32'h400 || wb_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reg_retire rv=%b pc=%h ready=%b mv=%b want 1/400/1/0",
                     retire_valid, retire_pc, wb_ready, mem_req_valid);
        end
        @(negedge clk);
        checks++;
        if (gpr_we !== 1'b0 || retire_valid !== 1'b0) begin
            errors++; $display("FAIL reg_pulse_width we=%b rv=%b want 0/0", gpr_we, retire_valid);
        end
        // Back-to-back register writes, one accept per cycle.
        for (int i = 0; i < 6; i++) begin
            d = $urandom(); s = 3'($urandom_range(0, 7)); pc = $urandom();
            checks++;
            if (wb_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready i=%0d got=%b want=1", i, wb_ready);
            end
            drive(32'h0, s, {32'hDEAD_BEEF, d}, 3'b011, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, pc);
            @(negedge clk);
            checks++;
            if (gpr_we !== 1'b1 || gpr_sel !== s || gpr_data !== d || retire_valid !== 1'b1 || retire_pc !== pc) begin
                errors++;
                $display("FAIL b2b_write i=%0d we=%b sel=%0d data=%h pc=%h want 1/%0d/%h/%h",
                         i, gpr_we, gpr_sel, gpr_data, retire_pc, s, d, pc);
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_aligned_store();
        mem_req_ready = 1'b1;
        drive(32'h1000, 3'd0, 64'hAABB_CCDD, 3'b011, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000 || mem_req_be !== 4'b1111 ||
            mem_req_data !== 32'hAABB_CCDD || wb_ready !== 1'b0 || retire_valid !== 1'b0) begin
            errors++;
            $display("FAIL aligned_beat v=%b addr=%h be=%b data=%h ready=%b rv=%b want 1/1000/1111/aabbccdd/0/0",
                     mem_req_valid, mem_req_addr, mem_req_be, mem_req_data, wb_ready, retire_valid);
        end
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b0 || retire_valid !== 1'b1 || retire_pc !== 32'h500 || wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL aligned_retire v=%b rv=%b pc=%h ready=%b want 0/1/500/1",
                     mem_req_valid, retire_valid, retire_pc, wb_ready);
        end
        mem_req_ready = 1'b0;
    endtask

    task automatic test_unaligned_store();
        mem_req_ready = 1'b1;
        drive(32'h1003, 3'd0, 64'hBEEF, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h504);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000 || mem_req_be !== 4'b1000 ||
            mem_req_data !== 32'hEF00_0000) begin
            errors++;
            $display("FAIL unaligned_beat0 v=%b addr=%h be=%b data=%h want 1/1000/1000/ef000000",
                     mem_req_valid, mem_req_addr, mem_req_be, mem_req_data);
        end
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1004 || mem_req_be !== 4'b0001 ||
            mem_req_data !== 32'h0000_00BE || wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL unaligned_beat1 v=%b addr=%h be=%b data=%h ready=%b want 1/1004/0001/000000be/0",
                     mem_req_valid, mem_req_addr, mem_req_be, mem_req_data, wb_ready);
        end
        @(negedge clk);
        checks++;
        if (retire_valid !== 1'b1 || retire_pc !== 32'h504 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL unaligned_retire rv=%b pc=%h v=%b want 1/504/0", retire_valid, retire_pc, mem_req_valid);
        end
        mem_req_ready = 1'b0;
    endtask

`ifdef WB_MMX_EN
    task automatic test_mmx_store();
        mem_req_ready = 1'b1;
        drive(32'h2002, 3'd0, 64'h1122_3344_5566_7788, 3'b100, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h600);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (mem_req_addr !== 32'h2000 || mem_req_be !== 4'b1100 || mem_req_data !== 32'h7788_0000) begin
            errors++;
            $display("FAIL mmx_beat0 addr=%h be=%b data=%h want 2000/1100/77880000", mem_req_addr, mem_req_be, mem_req_data);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2004 || mem_req_be !== 4'b1111 ||
                mem_req_data !== 32'h3344_5566) begin
                errors++;
                $display("FAIL mmx_beat1_stall i=%0d v=%b addr=%h be=%b data=%h want 1/2004/1111/33445566",
                         i, mem_req_valid, mem_req_addr, mem_req_be, mem_req_data);
            end
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req_addr !== 32'h2008 || mem_req_be !== 4'b0011 || mem_req_data !== 32'h0000_1122) begin
            errors++;
            $display("FAIL mmx_beat2 addr=%h be=%b data=%h want 2008/0011/00001122", mem_req_addr, mem_req_be, mem_req_data);
        end
        @(negedge clk);
        checks++;
        if (retire_valid !== 1'b1 || retire_pc !== 32'h600 || wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL mmx_retire rv=%b pc=%h ready=%b want 1/600/1", retire_valid, retire_pc, wb_ready);
        end
        mem_req_ready = 1'b0;
    endtask
`endif

    task automatic test_push_pop();
        mem_req_ready = 1'b1;
        drive(32'h0FFC, 3'd5, 64'h0BAD_F00D, 3'b011, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 32'h700);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (esp_dec !== 1'b1 || esp_inc !== 1'b0 || esp_delta !== 4'd4 || gpr_we !== 1'b0) begin
            errors++;
            $display("FAIL push_esp dec=%b inc=%b delta=%0d gpr_we=%b want 1/0/4/0", esp_dec, esp_inc, esp_delta, gpr_we);
        end
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0FFC || mem_req_be !== 4'b1111 ||
            mem_req_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL push_beat v=%b addr=%h be=%b data=%h want 1/0ffc/1111/0badf00d",
                     mem_req_valid, mem_req_addr, mem_req_be, mem_req_data);
        end
        @(negedge clk);
        checks++;
        if (esp_dec !== 1'b0 || retire_valid !== 1'b1 || retire_pc !== 32'h700 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL push_retire dec=%b rv=%b pc=%h v=%b want 0/1/700/0", esp_dec, retire_valid, retire_pc, mem_req_valid);
        end
        mem_req_ready = 1'b0;
        drive(32'h0, 3'd0, 64'hCAFE, 3'b010, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h704);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (gpr_we !== 1'b1 || gpr_sel !== 3'd0 || gpr_data !== 32'h0000_CAFE || gpr_size !== 3'b010 ||
            esp_inc !== 1'b1 || esp_dec !== 1'b0 || esp_delta !== 4'd2 || retire_valid !== 1'b1) begin
            errors++;
            $display("FAIL pop we=%b sel=%0d data=%h size=%b inc=%b dec=%b delta=%0d rv=%b want 1/0/cafe/010/1/0/2/1",
                     gpr_we, gpr_sel, gpr_data, gpr_size, esp_inc, esp_dec, esp_delta, retire_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] addr, pc, ea;
        logic [63:0] res;
        logic [2:0]  sz, sel;
        logic [1:0]  st;
        logic        a, r, s, m, rdy;
        int          n, o, dest, beats, k, budget;
        mem_req_ready = 1'b0;
        for (int it = 0; it < 80; it++) begin
            addr = $urandom();
            if ($urandom_range(0, 3) == 0) addr[31:2] = '1;
            res = {$urandom(), $urandom()};
            sz  = 3'($urandom_range(0, 7));
            st  = 2'($urandom_range(0, 3));
            sel = 3'($urandom_range(0, 7));
            a = 1'($urandom()); r = 1'($urandom()); s = 1'($urandom()); m = 1'($urandom());
            pc = $urandom();
            n = model_bytes(sz);
            o = int'(addr[1:0]);
            dest = model_dest(st, a, r, s, m);
            beats = (o + n + 3) / 4;
            checks++;
            if (wb_ready !== 1'b1) begin
                errors++; $display("FAIL rand_ready it=%0d got=%b want=1", it, wb_ready);
            end
            drive(addr, sel, res, sz, st, a, r, s, m, pc);
            @(negedge clk);
            idle_inputs();
            checks++;
            if (esp_dec !== (st == 2'b01) || esp_inc !== (st == 2'b10) ||
                ((st == 2'b01 || st == 2'b10) && esp_delta !== 4'(n))) begin
                errors++;
                $display("FAIL rand_esp it=%0d dec=%b inc=%b delta=%0d want st=%b delta=%0d",
                         it, esp_dec, esp_inc, esp_delta, st, n);
            end
            if (dest == 4) begin
                checks++;
                if (retire_valid !== 1'b0 || wb_ready !== 1'b0) begin
                    errors++; $display("FAIL rand_store_busy it=%0d rv=%b ready=%b want 0/0", it, retire_valid, wb_ready);
                end
                k = 0;
                budget = 0;
                while (k < beats && budget < 60) begin
                    ea = (addr & 32'hFFFF_FFFC) + 32'(4 * k);
                    checks++;
                    if (mem_req_valid !== 1'b1 || mem_req_addr !== ea || mem_req_be !== model_be(o, n, k) ||
                        mem_req_data !== model_data(res, o, k)) begin
                        errors++;
                        $display("FAIL rand_beat it=%0d k=%0d v=%b addr=%h be=%b data=%h want addr=%h be=%b data=%h",
                                 it, k, mem_req_valid, mem_req_addr, mem_req_be, mem_req_data,
                                 ea, model_be(o, n, k), model_data(res, o, k));
                    end
                    rdy = ($urandom_range(0, 2) != 0);
                    mem_req_ready = rdy;
                    @(negedge clk);
                    budget++;
                    if (rdy) k++;
                end
                mem_req_ready = 1'b0;
                checks++;
                if (k < beats) begin
                    errors++; $display("FAIL rand_store_timeout it=%0d beats_done=%0d want %0d", it, k, beats);
                end
                checks++;
                if (retire_valid !== 1'b1 || retire_pc !== pc || mem_req_valid !== 1'b0 || wb_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_store_retire it=%0d rv=%b pc=%h v=%b ready=%b want 1/%h/0/1",
                             it, retire_valid, retire_pc, mem_req_valid, wb_ready, pc);
                end
            end else begin
                checks++;
                if ({gpr_we, seg_we, mmx_we, mem_req_valid, retire_valid} !==
                    {dest == 1, dest == 2, dest == 3, 1'b0, 1'b1} || retire_pc !== pc) begin
                    errors++;
                    $display("FAIL rand_reg_strobes it=%0d gpr=%b seg=%b mmx=%b mv=%b rv=%b pc=%h want dest=%0d pc=%h",
                             it, gpr_we, seg_we, mmx_we, mem_req_valid, retire_valid, retire_pc, dest, pc);
                end
                checks++;
                if ((dest == 1 && (gpr_sel !== sel || gpr_data !== res[31:0] || gpr_size !== model_code(sz))) ||
                    (dest == 2 && (seg_sel !== sel || seg_data !== res[15:0])) ||
                    (dest == 3 && (mmx_sel !== sel || mmx_data !== res))) begin
                    errors++;
                    $display("FAIL rand_reg_data it=%0d dest=%0d gsel=%0d gdata=%h gsize=%b ssel=%0d sdata=%h msel=%0d mdata=%h want sel=%0d res=%h size=%b",
                             it, dest, gpr_sel, gpr_data, gpr_size, seg_sel, seg_data, mmx_sel, mmx_data,
                             sel, res, model_code(sz));
                end
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_store();
        mem_req_ready = 1'b1;
        drive(32'h3003, 3'd0, 64'h0102_0304, 3'b011, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h800);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3004 || mem_req_be !== 4'b0111) begin
            errors++;
            $display("FAIL rst_mid_beat1 v=%b addr=%h be=%b want 1/3004/0111", mem_req_valid, mem_req_addr, mem_req_be);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || wb_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async v=%b ready=%b want 0/0", mem_req_valid, wb_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_ready !== 1'b1 || retire_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release ready=%b rv=%b v=%b want 1/0/0", wb_ready, retire_valid, mem_req_valid);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (retire_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                errors++; $display("FAIL rst_mid_no_retire rv=%b v=%b want 0/0", retire_valid, mem_req_valid);
            end
        end
        mem_req_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        mem_req_ready = 1'b0;
        test_reset();
        test_reg_write();
        test_aligned_store();
        test_unaligned_store();
`ifdef WB_MMX_EN
        test_mmx_store();
`endif
        test_push_pop();
        test_random();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
